bcd_seq_addsub: RTL and testbench

BCD_SEQ_ADDSUB -- requirements
Module: bcd_seq_addsub

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_seq_addsub_if.sv | 38 +++
 rtl/bcd_digit_add.sv | 27 ++
 rtl/bcd_seq_addsub.sv | 157 +++++++++++++++
 tb/tb_bcd_seq_addsub.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the sequential BCD adder/subtractor:
//   state_t     - controller states (IDLE, CHECK, RUN, DONE)
//   BCD_MAX     - largest legal BCD digit value
//   BCD_RADIX   - decimal radix used by the digit correction
//   nines_comp  - nine's complement of one BCD digit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return 4'(BCD_MAX) - digit;
  endfunction

endpackage

// File: rtl/bcd_seq_addsub_if.sv
// bcd_seq_addsub_if
// Operand/result bundle for bcd_seq_addsub.
//   start   - request to accept operands
//   sub     - 0 = a+b, 1 = a-b
//   a, b    - packed BCD operands, LSD in bits [3:0]
//   cin     - carry-in (add) / borrow-in (sub)
//   busy    - operation in progress
//   done    - one-cycle completion pulse
//   result  - packed BCD result
//   cout    - carry-out (add) / no-borrow flag (sub)
//   invalid - a captured nibble exceeded 9
// master drives the request side, slave is the arithmetic block.
interface bcd_seq_addsub_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  invalid;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, result, cout, invalid
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, result, cout, invalid
  );

endinterface

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
// Combinational single-digit decimal adder with correction.
//   x, y - BCD digits (y is already complemented for subtraction)
//   ci   - incoming decimal carry
//   d    - corrected BCD sum digit
//   co   - outgoing decimal carry
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co
);

  // Worst case 9+9+1 = 19 fits in five bits, so the binary sum never wraps.
  logic [4:0] sum;

  assign sum = {1'b0, x} + {1'b0, y} + {4'b0, ci};

  always_comb begin
    co = (sum > 5'(BCD_MAX));
    d  = co ? 4'(sum - 5'(BCD_RADIX)) : sum[3:0];
  end

endmodule

// File: rtl/bcd_seq_addsub.sv
// bcd_seq_addsub
// Sequential BCD adder/subtractor: one digit per clock, LSD first,
// through a single time-shared bcd_digit_add.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of bcd_seq_addsub_if (operands, control, result)
// Subtraction adds the nine's complement of b with an initial carry of
// ~cin, so a negative difference lands as its ten's complement, cout=0.
module bcd_seq_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_seq_addsub_if.slave     bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state;
  state_t          next_state;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            sub_q;
  logic            c_q;
  logic            cout_q;
  logic            invalid_q;
  logic [IW-1:0]   idx;

  logic            accept;
  logic            any_bad;
  logic            last_digit;
  logic            busy_c;
  logic            done_c;
  logic [3:0]      x_dig;
  logic [3:0]      b_dig;
  logic [3:0]      y_dig;
  logic [3:0]      d_dig;
  logic            co;

  // New operands are only taken when no operation is in flight.
  assign accept     = bus.start && ((state == IDLE) || (state == DONE));
  assign last_digit = (idx == IW'(DIGITS - 1));

  // Any non-decimal nibble in either captured operand poisons the operation.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a_q[4*i +: 4] > 4'(BCD_MAX)) || (b_q[4*i +: 4] > 4'(BCD_MAX)))
        any_bad = 1'b1;
    end
  end

  // Select the digit pair for the current index.
  always_comb begin
    x_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        x_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    y_dig = sub_q ? nines_comp(b_dig) : b_dig;
  end

  bcd_digit_add u_digit (
    .x  (x_dig),
    .y  (y_dig),
    .ci (c_q),
    .d  (d_dig),
    .co (co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = CHECK;
      CHECK:   next_state = any_bad ? DONE : RUN;
      RUN:     if (last_digit) next_state = DONE;
      DONE:    next_state = bus.start ? CHECK : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy_c = (state == CHECK) || (state == RUN);
    done_c = (state == DONE);
  end

  // Datapath: operand capture, validity check and digit-serial accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      c_q       <= 1'b0;
      idx       <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else if (accept) begin
      a_q       <= bus.a;
      b_q       <= bus.b;
      sub_q     <= bus.sub;
      c_q       <= bus.sub ? ~bus.cin : bus.cin;
      idx       <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state)
        CHECK: begin
          if (any_bad) begin
            invalid_q <= 1'b1;
            result_q  <= '0;
            cout_q    <= 1'b0;
          end else begin
            invalid_q <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i))
              result_q[4*i +: 4] <= d_dig;
          end
          c_q <= co;
          idx <= idx + 1'b1;
          if (last_digit)
            cout_q <= co;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_seq_addsub.sv
// tb_bcd_seq_addsub
// Self-checking bench for bcd_seq_addsub (DIGITS=4): directed cases,
// randomized operations against a decimal-arithmetic reference model,
// start-ignored-in-RUN, DONE-to-CHECK chaining and mid-operation reset.
module tb_bcd_seq_addsub;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_seq_addsub_if #(.DIGITS(D)) bus ();

  bcd_seq_addsub #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic longint modulus();
    longint m = 1;
    for (int i = 0; i < D; i++) m = m * 10;
    return m;
  endfunction

  function automatic longint bcd_to_int(input logic [W-1:0] x);
    longint v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: plain decimal arithmetic on the operand values.
  task automatic ref_model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic ci, output logic [W-1:0] r,
                           output logic co, output logic inv);
    longint va, vb, t;
    inv = 1'b0;
    for (int i = 0; i < D; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) inv = 1'b1;
    if (inv) begin
      r  = '0;
      co = 1'b0;
    end else begin
      va = bcd_to_int(av);
      vb = bcd_to_int(bv);
      if (!s) begin
        t  = va + vb + longint'(ci);
        co = (t >= modulus());
        r  = int_to_bcd(t % modulus());
      end else begin
        t  = va - vb - longint'(ci);
        co = (t >= 0);
        r  = int_to_bcd(t >= 0 ? t : t + modulus());
      end
    end
  endtask

  // Present operands with start for one edge, then scramble the inputs so
  // the DUT has to rely on its captured copies.
  task automatic apply_stimulus(input logic s, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input logic ci);
    bus.sub   = s;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.sub   = 1'($urandom);
    bus.cin   = 1'($urandom);
    check_output("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  // Count edges after the sampling edge until done; pre = edges already spent.
  task automatic wait_done(input string tag, input int pre, input logic [W-1:0] exp_res,
                           input logic exp_co, input logic exp_inv);
    int n = pre;
    bit seen = 1'b0;
    int exp_lat = exp_inv ? 1 : D + 1;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    check_output({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check_output({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    check_output({tag, "_cout"}, {63'd0, bus.cout}, {63'd0, exp_co});
    check_output({tag, "_invalid"}, {63'd0, bus.invalid}, {63'd0, exp_inv});
    check_output({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic run_exp(input string tag, input logic s, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ci,
                         input logic [W-1:0] exp_res, input logic exp_co,
                         input logic exp_inv);
    apply_stimulus(s, av, bv, ci);
    wait_done(tag, 0, exp_res, exp_co, exp_inv);
  endtask

  // One idle cycle after done: pulse must drop and outputs must hold.
  task automatic hold_check(input string tag, input logic [W-1:0] exp_res);
    @(posedge clk);
    #1;
    check_output({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    check_output({tag, "_held"}, 64'(bus.result), 64'(exp_res));
  endtask

  initial begin
    logic [W-1:0] av, bv, er;
    logic         s, ci, eco, einv;
    bit           seen;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", {63'd0, bus.busy}, 64'd0);
    check_output("reset_done", {63'd0, bus.done}, 64'd0);
    check_output("reset_result", 64'(bus.result), 64'd0);
    check_output("reset_cout", {63'd0, bus.cout}, 64'd0);
    check_output("reset_invalid", {63'd0, bus.invalid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed cases");
    run_exp("add_6_9", 1'b0, 16'h0006, 16'h0009, 1'b0, 16'h0015, 1'b0, 1'b0);
    hold_check("add_6_9", 16'h0015);
    run_exp("add_9999_1", 1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_exp("add_3_3_cin", 1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0007, 1'b0, 1'b0);
    hold_check("add_3_3_cin", 16'h0007);
    run_exp("sub_13_4", 1'b1, 16'h0013, 16'h0004, 1'b0, 16'h0009, 1'b1, 1'b0);
    run_exp("sub_4_13", 1'b1, 16'h0004, 16'h0013, 1'b0, 16'h9991, 1'b0, 1'b0);
    hold_check("sub_4_13", 16'h9991);
    run_exp("invalid_a", 1'b0, 16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_exp("after_invalid", 1'b0, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0);
    hold_check("after_invalid", 16'h0046);

    $display("[TB] start ignored during RUN");
    apply_stimulus(1'b0, 16'h1234, 16'h5678, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.a     = 16'h9999;
    bus.b     = 16'h0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignore_in_run", 2, 16'h6912, 1'b0, 1'b0);
    hold_check("ignore_in_run", 16'h6912);

    $display("[TB] randomized operations (back-to-back, chained from DONE)");
    for (int i = 0; i < 40; i++) begin
      av = int_to_bcd(longint'($urandom) % modulus());
      bv = int_to_bcd(longint'($urandom) % modulus());
      s  = 1'($urandom);
      ci = 1'($urandom);
      if ($urandom_range(7) == 0) begin
        int pos = $urandom_range(D - 1);
        if ($urandom_range(1) == 0) av[4*pos +: 4] = 4'($urandom_range(15, 10));
        else                        bv[4*pos +: 4] = 4'($urandom_range(15, 10));
      end
      ref_model(s, av, bv, ci, er, eco, einv);
      run_exp($sformatf("rand%0d", i), s, av, bv, ci, er, eco, einv);
    end
    hold_check("rand_tail", er);

    $display("[TB] reset during RUN digit 2");
    apply_stimulus(1'b0, 16'h1111, 16'h2222, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_busy", {63'd0, bus.busy}, 64'd0);
    check_output("abort_done", {63'd0, bus.done}, 64'd0);
    check_output("abort_result", 64'(bus.result), 64'd0);
    check_output("abort_cout", {63'd0, bus.cout}, 64'd0);
    check_output("abort_invalid", {63'd0, bus.invalid}, 64'd0);
    @(posedge clk);
    #1;
    check_output("start_in_reset_busy", {63'd0, bus.busy}, 64'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    seen      = 1'b0;
    repeat (D + 4) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check_output("no_done_after_abort", {63'd0, seen}, 64'd0);

    run_exp("recover", 1'b1, 16'h5000, 16'h0001, 1'b1, 16'h4998, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
